// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX-stage controller and the multiply/divide unit.
// The master side is the pipeline; the slave side is the unit holding HI/LO.
interface ex_muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Multiply has a fixed MUL_CYCLES latency; divide is restoring radix-2 over 32 cycles.
module ex_muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2((MUL_CYCLES > 32) ? MUL_CYCLES : 32);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [32:0]      ma_q, ma_d, mb_q, mb_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dzero_q, dzero_d;

    logic        accept;
    logic        sgn;
    logic        last_mul;
    logic        last_div;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic [31:0] quo_nx;
    logic [31:0] rem_nx;

    assign accept   = bus.start && !bus.flush && (state_q == IDLE);
    assign sgn      = ~bus.op[0];
    assign last_mul = (cnt_q == CNT_W'(MUL_CYCLES - 1));
    assign last_div = (cnt_q == CNT_W'(31));

    // Operands are stored 33-bit extended; the low 64 bits of the extended product are exact.
    assign prod = {{31{ma_q[32]}}, ma_q} * {{31{mb_q[32]}}, mb_q};

    assign shifted = {rem_q, quo_q[31]};

    always_comb begin
        quo_nx = {quo_q[30:0], 1'b0};
        rem_nx = shifted[31:0];
        if (shifted >= {1'b0, dvs_q}) begin
            quo_nx = {quo_q[30:0], 1'b1};
            rem_nx = 32'(shifted - {1'b0, dvs_q});
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        ma_d    = ma_q;
        mb_d    = mb_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzero_d = dzero_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (bus.op)
                        3'd0, 3'd1: begin
                            state_d = MUL;
                            cnt_d   = '0;
                            ma_d    = {sgn & bus.a[31], bus.a};
                            mb_d    = {sgn & bus.b[31], bus.b};
                        end
                        3'd2, 3'd3: begin
                            // Divide on magnitudes; signs are reapplied on the final write.
                            state_d = DIV;
                            cnt_d   = '0;
                            quo_d   = (sgn && bus.a[31]) ? -bus.a : bus.a;
                            dvs_d   = (sgn && bus.b[31]) ? -bus.b : bus.b;
                            rem_d   = '0;
                            qneg_d  = sgn && (bus.a[31] ^ bus.b[31]);
                            rneg_d  = sgn && bus.a[31];
                            dzero_d = (bus.b == '0);
                        end
                        3'd4: hi_d = bus.a;
                        3'd5: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last_mul) begin
                    state_d      = IDLE;
                    done_d       = 1'b1;
                    {hi_d, lo_d} = prod;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    quo_d = quo_nx;
                    rem_d = rem_nx;
                    if (last_div) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        if (!dzero_q) begin
                            lo_d = qneg_q ? -quo_nx : quo_nx;
                            hi_d = rneg_q ? -rem_nx : rem_nx;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzero_q <= dzero_d;
        end
    end

    assign bus.busy = (state_q != IDLE) || (bus.start && !bus.flush && !bus.op[2]);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
